// File: rtl/lift_pkg.sv
// Shared definitions for the lift request scheduler: state encoding, default sizing
// and the floor-index to one-hot helper.
package lift_pkg;

    localparam int NUM_FLOORS_DEF = 4;
    localparam int FLOOR_W_DEF    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DWELL = 2'd2,
        HALT  = 2'd3
    } lift_state_t;

    function automatic logic [NUM_FLOORS_DEF-1:0] onehot_floor(input logic [FLOOR_W_DEF-1:0] floor_idx);
        logic [NUM_FLOORS_DEF-1:0] v;
        v = '0;
        v[floor_idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/lift_scan_picker.sv
// Combinational SCAN chooser: nearest pending floor in the sweep direction, otherwise the
// nearest one behind (reversing the sweep), otherwise the current floor if it is pending.
module lift_scan_picker
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS = NUM_FLOORS_DEF,
    parameter int FLOOR_W    = FLOOR_W_DEF
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  dir_up,
    output logic [FLOOR_W-1:0]    pick,
    output logic                  pick_valid,
    output logic                  new_dir
);

    logic [FLOOR_W-1:0] above;
    logic [FLOOR_W-1:0] below;
    logic               found_above;
    logic               found_below;

    // Scanning toward the current floor leaves the closest candidate as the last assignment.
    always_comb begin
        above       = '0;
        below       = '0;
        found_above = 1'b0;
        found_below = 1'b0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(current_floor))) begin
                found_above = 1'b1;
                above       = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i < int'(current_floor))) begin
                found_below = 1'b1;
                below       = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        pick       = current_floor;
        pick_valid = pending[current_floor];
        new_dir    = dir_up;
        if (dir_up) begin
            if (found_above) begin
                pick       = above;
                pick_valid = 1'b1;
            end else if (found_below) begin
                pick       = below;
                pick_valid = 1'b1;
                new_dir    = 1'b0;
            end
        end else begin
            if (found_below) begin
                pick       = below;
                pick_valid = 1'b1;
            end else if (found_above) begin
                pick       = above;
                pick_valid = 1'b1;
                new_dir    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lift_request_scheduler.sv
// Lift front end: latches call-button edges, schedules targets with SCAN, drives a single
// one-hot floor request to the controller and holds the door open on each stop.
module lift_request_scheduler
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS   = NUM_FLOORS_DEF,
    parameter int FLOOR_W      = FLOOR_W_DEF,
    parameter int DWELL_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic                  emergency_stop,
    input  logic                  c_up,
    input  logic                  c_down,
    input  logic                  motor_stop,
    input  logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] floor_req,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  door_open,
    output logic                  dir_up
);

    localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW_W-1:0] DWELL_LOAD = DW_W'(DWELL_CYCLES - 1);

    lift_state_t           state, state_next;
    logic [NUM_FLOORS-1:0] btn_q, rise, cur_mask, between_mask;
    logic [NUM_FLOORS-1:0] pending_next, floor_req_next;
    logic [FLOOR_W-1:0]    target_q, target_next;
    logic [DW_W-1:0]       dwell_cnt, dwell_next;
    logic                  dir_next, door_next;
    logic                  arrival, travel_up;
    logic [FLOOR_W-1:0]    pick, enroute_pick;
    logic                  pick_valid, new_dir, enroute_valid, enroute_dir;

    assign rise      = btn & ~btn_q;
    assign cur_mask  = onehot_floor(current_floor);
    assign arrival   = motor_stop & ~c_up & ~c_down & (current_floor == target_q);
    assign travel_up = (target_q > current_floor);

    // Floors strictly between the car and its target are candidates for an en-route stop.
    always_comb begin
        between_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (((i > int'(current_floor)) && (i < int'(target_q))) ||
                ((i < int'(current_floor)) && (i > int'(target_q))))
                between_mask[i] = 1'b1;
        end
    end

    lift_scan_picker #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_pick (
        .pending       (pending),
        .current_floor (current_floor),
        .dir_up        (dir_up),
        .pick          (pick),
        .pick_valid    (pick_valid),
        .new_dir       (new_dir)
    );

    lift_scan_picker #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_enroute (
        .pending       (pending & between_mask),
        .current_floor (current_floor),
        .dir_up        (travel_up),
        .pick          (enroute_pick),
        .pick_valid    (enroute_valid),
        .new_dir       (enroute_dir)
    );

    always_comb begin
        state_next   = state;
        pending_next = pending | rise;
        target_next  = target_q;
        dir_next     = dir_up;
        dwell_next   = dwell_cnt;
        door_next    = door_open;
        if (emergency_stop) begin
            state_next = HALT;
            door_next  = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pending != '0) begin
                        if (pending[current_floor] && motor_stop) begin
                            state_next = DWELL;
                        end else if (pick_valid) begin
                            target_next = pick;
                            dir_next    = new_dir;
                            state_next  = SERVE;
                        end
                    end
                end
                SERVE: begin
                    if (arrival)
                        state_next = DWELL;
                    else if (enroute_valid && (enroute_dir == travel_up))
                        target_next = enroute_pick;
                end
                DWELL: begin
                    if (rise[current_floor]) begin
                        dwell_next = DWELL_LOAD;
                    end else if (dwell_cnt == '0) begin
                        state_next = IDLE;
                        door_next  = 1'b0;
                    end else begin
                        dwell_next = dwell_cnt - 1'b1;
                    end
                end
                HALT:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
            if ((state != DWELL) && (state_next == DWELL)) begin
                door_next  = 1'b1;
                dwell_next = DWELL_LOAD;
            end
        end
        // While the door is open at a floor, its request is served and new presses there are absorbed.
        if (state_next == DWELL)
            pending_next = pending_next & ~cur_mask;
        floor_req_next = (state_next == SERVE) ? onehot_floor(target_next) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= '0;
            floor_req <= '0;
            door_open <= 1'b0;
            dir_up    <= 1'b1;
            target_q  <= '0;
            dwell_cnt <= '0;
            btn_q     <= '0;
        end else begin
            state     <= state_next;
            pending   <= pending_next;
            floor_req <= floor_req_next;
            door_open <= door_next;
            dir_up    <= dir_next;
            target_q  <= target_next;
            dwell_cnt <= dwell_next;
            btn_q     <= btn;
        end
    end

endmodule

// File: tb/tb_lift_request_scheduler.sv
// Scoreboard bench for lift_request_scheduler: a simple car model closes the loop, and a
// floor-level reference model predicts every output cycle by cycle.
module tb_lift_request_scheduler;

    localparam int NF    = 4;
    localparam int DWELL = 8;
    localparam int MODE_IDLE  = 0;
    localparam int MODE_SERVE = 1;
    localparam int MODE_DWELL = 2;
    localparam int MODE_HALT  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [NF-1:0] btn;
    logic          emergency_stop;
    logic          c_up, c_down, motor_stop;
    logic [1:0]    current_floor;
    logic [NF-1:0] floor_req, pending;
    logic          door_open, dir_up;

    typedef struct packed {
        logic [NF-1:0] floor_req;
        logic [NF-1:0] pending;
        logic          door_open;
        logic          dir_up;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    logic [NF-1:0] m_pend, m_prev;
    int            m_mode, m_goal, m_left;
    bit            m_dir;

    // Car model state
    int plant_floor = 0;
    int plant_travel = 0;

    lift_request_scheduler #(.NUM_FLOORS(NF), .FLOOR_W(2), .DWELL_CYCLES(DWELL)) dut (
        .clk            (clk),
        .reset          (reset),
        .btn            (btn),
        .emergency_stop (emergency_stop),
        .c_up           (c_up),
        .c_down         (c_down),
        .motor_stop     (motor_stop),
        .current_floor  (current_floor),
        .floor_req      (floor_req),
        .pending        (pending),
        .door_open      (door_open),
        .dir_up         (dir_up)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        check_val("floor_req", 8'(floor_req), 8'(e.floor_req));
        check_val("pending", 8'(pending), 8'(e.pending));
        check_val("door_open", 8'(door_open), 8'(e.door_open));
        check_val("dir_up", 8'(dir_up), 8'(e.dir_up));
        check_val("floor_req_onehot", 8'($countones(floor_req) <= 1), 8'd1);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0)
            checkOutput(sb_q.pop_front());
    end

    task automatic model_reset();
        m_pend = '0;
        m_prev = '0;
        m_mode = MODE_IDLE;
        m_goal = 0;
        m_left = 0;
        m_dir  = 1'b1;
    endtask

    // SCAN rule: search outward by distance, preferring the side ahead of the sweep.
    task automatic ref_pick(input logic [NF-1:0] p, input int cf, input bit d, output int f, output bit nd);
        int up_f, dn_f;
        up_f = -1;
        dn_f = -1;
        for (int k = 1; k < NF; k++) begin
            if (up_f < 0 && cf + k < NF && p[cf + k]) up_f = cf + k;
            if (dn_f < 0 && cf - k >= 0 && p[cf - k]) dn_f = cf - k;
        end
        f  = cf;
        nd = d;
        if (d) begin
            if (up_f >= 0) begin f = up_f; nd = 1'b1; end
            else if (dn_f >= 0) begin f = dn_f; nd = 1'b0; end
        end else begin
            if (dn_f >= 0) begin f = dn_f; nd = 1'b0; end
            else if (up_f >= 0) begin f = up_f; nd = 1'b1; end
        end
    endtask

    // Advance the reference by one clock edge using the inputs present at that edge.
    task automatic model_step();
        logic [NF-1:0] rise, old, here, one;
        int  cf, f, step, span;
        bit  nd, found;
        one  = 4'b0001;
        cf   = int'(current_floor);
        here = one << cf;
        rise = btn & ~m_prev;
        m_prev = btn;
        old    = m_pend;
        m_pend = old | rise;
        if (emergency_stop) begin
            m_mode = MODE_HALT;
        end else if (m_mode == MODE_HALT) begin
            m_mode = MODE_IDLE;
        end else if (m_mode == MODE_IDLE) begin
            if (old != 0) begin
                if (old[cf] && motor_stop) begin
                    m_mode = MODE_DWELL;
                    m_left = DWELL;
                end else begin
                    ref_pick(old, cf, m_dir, f, nd);
                    m_goal = f;
                    m_dir  = nd;
                    m_mode = MODE_SERVE;
                end
            end
        end else if (m_mode == MODE_SERVE) begin
            if (motor_stop && !c_up && !c_down && cf == m_goal) begin
                m_mode = MODE_DWELL;
                m_left = DWELL;
            end else begin
                step  = (m_goal > cf) ? 1 : -1;
                span  = (m_goal > cf) ? m_goal - cf : cf - m_goal;
                found = 1'b0;
                for (int k = 1; k < span; k++) begin
                    if (!found && old[cf + k * step]) begin
                        m_goal = cf + k * step;
                        found  = 1'b1;
                    end
                end
            end
        end else begin
            if (rise[cf]) m_left = DWELL;
            else if (m_left == 1) m_mode = MODE_IDLE;
            else m_left--;
        end
        if (m_mode == MODE_DWELL)
            m_pend = m_pend & ~here;
    endtask

    task automatic push_expected();
        exp_t e;
        logic [NF-1:0] one;
        one = 4'b0001;
        e.floor_req = (m_mode == MODE_SERVE) ? (one << m_goal) : '0;
        e.pending   = m_pend;
        e.door_open = (m_mode == MODE_DWELL);
        e.dir_up    = m_dir;
        sb_q.push_back(e);
    endtask

    // Car model: stops on emergency or with no target, otherwise one floor every three cycles.
    task automatic plant_step();
        int tgt;
        tgt = -1;
        for (int i = 0; i < NF; i++)
            if (floor_req[i]) tgt = i;
        if (emergency_stop || tgt < 0 || tgt == plant_floor) begin
            c_up = 1'b0; c_down = 1'b0; motor_stop = 1'b1; plant_travel = 0;
        end else begin
            if ((tgt > plant_floor && c_up) || (tgt < plant_floor && c_down)) plant_travel++;
            if (plant_travel >= 3) begin
                plant_floor += (tgt > plant_floor) ? 1 : -1;
                plant_travel = 0;
            end
            if (tgt == plant_floor) begin
                c_up = 1'b0; c_down = 1'b0; motor_stop = 1'b1;
            end else begin
                c_up = (tgt > plant_floor); c_down = (tgt < plant_floor); motor_stop = 1'b0;
            end
        end
        current_floor = 2'(plant_floor);
    endtask

    task automatic applyStimulus(input logic [NF-1:0] b, input logic e);
        @(posedge clk);
        #1;
        model_step();
        push_expected();
        plant_step();
        btn = b;
        emergency_stop = e;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) applyStimulus('0, 1'b0);
    endtask

    initial begin
        logic [NF-1:0] one;
        int est_left;
        one = 4'b0001;
        est_left = 0;
        reset = 1'b1;
        btn = '0;
        emergency_stop = 1'b0;
        c_up = 1'b0; c_down = 1'b0; motor_stop = 1'b1;
        current_floor = 2'd0;
        model_reset();
        #12;
        checkOutput('{floor_req: 4'b0000, pending: 4'b0000, door_open: 1'b0, dir_up: 1'b1});
        @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] scenario: single call to floor 2");
        applyStimulus(4'b0100, 1'b0);
        idle_cycles(45);

        $display("[TB] scenario: SCAN order from floor 1 going up");
        applyStimulus(4'b0001, 1'b0); idle_cycles(30);
        applyStimulus(4'b0010, 1'b0); idle_cycles(30);
        applyStimulus(4'b1000, 1'b0); applyStimulus('0, 1'b0);
        applyStimulus(4'b0001, 1'b0); idle_cycles(90);

        $display("[TB] scenario: en-route pickup");
        applyStimulus(4'b1000, 1'b0);
        for (int n = 0; n < 40 && current_floor != 2'd1; n++) applyStimulus('0, 1'b0);
        check_val("reach_floor1", 8'(current_floor), 8'd1);
        applyStimulus(4'b0100, 1'b0);
        idle_cycles(60);

        $display("[TB] scenario: press at current floor while idle");
        applyStimulus(one << current_floor, 1'b0);
        idle_cycles(4);
        applyStimulus(one << current_floor, 1'b0);
        idle_cycles(20);

        $display("[TB] scenario: emergency stop mid-travel");
        applyStimulus(4'b0001, 1'b0);
        idle_cycles(5);
        applyStimulus('0, 1'b1);
        applyStimulus(4'b1000, 1'b1);
        applyStimulus('0, 1'b1);
        idle_cycles(80);

        $display("[TB] scenario: held buttons");
        repeat (20) applyStimulus(4'b1111, 1'b0);
        idle_cycles(150);

        $display("[TB] scenario: random traffic");
        for (int n = 0; n < 1500; n++) begin
            logic [NF-1:0] b;
            b = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            if (est_left > 0) est_left--;
            else if ($urandom_range(0, 150) == 0) est_left = $urandom_range(2, 8);
            applyStimulus(b, est_left > 0);
        end
        idle_cycles(100);

        $display("[TB] scenario: asynchronous reset mid-travel");
        applyStimulus((current_floor == 2'd3) ? 4'b0001 : 4'b1000, 1'b0);
        for (int n = 0; n < 20 && floor_req == '0; n++) applyStimulus('0, 1'b0);
        check_val("travel_before_reset", 8'(floor_req != '0), 8'd1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check_val("async_reset_floor_req", 8'(floor_req), 8'd0);
        check_val("async_reset_pending", 8'(pending), 8'd0);
        check_val("async_reset_dir_up", 8'(dir_up), 8'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        plant_step();
        applyStimulus(4'b0010, 1'b0);
        idle_cycles(60);

        @(negedge clk);
        #1;
        check_val("scoreboard_drained", 8'(sb_q.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
